// File: rtl/smi_chanmux_if.sv
// smi_chanmux_if: per-channel requester bytes in, single escaped byte stream out toward the smi TX port
interface smi_chanmux_if #(parameter int NCH = 4);
  logic [NCH-1:0] S_VALID;
  logic [NCH-1:0] S_READY;
  logic [8*NCH-1:0] S_DATA;
  logic M_VALID;
  logic M_READY;
  logic [7:0] M_DATA;
  modport master (input S_VALID, S_DATA, M_READY, output S_READY, M_VALID, M_DATA);
  modport slave (output S_VALID, S_DATA, M_READY, input S_READY, M_VALID, M_DATA);
endinterface

// File: rtl/smi_chanmux.sv
// smi_chanmux: round-robin mux of NCH byte streams onto one smi stream with escaped channel-switch headers
module smi_chanmux #(
  parameter int NCH = 4,
  parameter int MAX_BURST = 64,
  parameter int LGBURST = 8
) (
  input logic i_clk,
  input logic i_reset,
  smi_chanmux_if.master bus,
  output logic [3:0] o_chan,
  output logic o_busy
);
  typedef enum logic [2:0] {IDLE, HDR_ESC, HDR_CH, DATA, DATA_ESC} state_t;
  localparam logic [7:0] ESC = 8'h1B;
  localparam logic [LGBURST:0] MAXB = (LGBURST+1)'(MAX_BURST);
  state_t state_q, state_d;
  logic [3:0] g_q, g_d, last_q, last_d, cur_q, cur_d, gnt;
  logic cur_vld_q, cur_vld_d, m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d, sel_data;
  logic [LGBURST:0] cnt_q, cnt_d;
  logic [NCH-1:0] s_ready;
  logic slot_free, sel_valid;
  int best_dist;
  assign slot_free = !m_valid_q || bus.M_READY;
  always_comb begin
    gnt = '0;
    best_dist = NCH;
    for (int k = 0; k < NCH; k++) begin
      if (bus.S_VALID[k] && (k + 2*NCH - int'(last_q) - 1) % NCH < best_dist) begin
        best_dist = (k + 2*NCH - int'(last_q) - 1) % NCH;
        gnt = 4'(k);
      end
    end
  end
  always_comb begin
    sel_valid = 1'b0;
    sel_data = '0;
    s_ready = '0;
    for (int k = 0; k < NCH; k++) begin
      if (g_q == 4'(k)) begin
        sel_valid = bus.S_VALID[k];
        sel_data = bus.S_DATA[8*k +: 8];
        s_ready[k] = state_q == DATA && bus.S_VALID[k] && slot_free;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    last_d = last_q;
    cur_d = cur_q;
    cur_vld_d = cur_vld_q;
    cnt_d = cnt_q;
    m_valid_d = m_valid_q && !bus.M_READY;
    m_data_d = m_data_q;
    case (state_q)
      IDLE: if (|bus.S_VALID) begin
        g_d = gnt;
        last_d = gnt;
        cnt_d = '0;
        state_d = cur_vld_q && gnt == cur_q ? DATA : HDR_ESC;
      end
      HDR_ESC: if (slot_free) begin
        m_valid_d = 1'b1;
        m_data_d = ESC;
        state_d = HDR_CH;
      end
      HDR_CH: if (slot_free) begin
        m_valid_d = 1'b1;
        m_data_d = {4'h8, g_q};
        cur_d = g_q;
        cur_vld_d = 1'b1;
        state_d = DATA;
      end
      DATA: if (!sel_valid) state_d = IDLE;
      else if (slot_free) begin
        m_valid_d = 1'b1;
        m_data_d = sel_data;
        cnt_d = cnt_q + 1'b1;
        state_d = sel_data == ESC ? DATA_ESC : cnt_d == MAXB ? IDLE : DATA;
      end
      DATA_ESC: if (slot_free) begin
        m_valid_d = 1'b1;
        m_data_d = ESC;
        state_d = cnt_q == MAXB ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      g_q <= '0;
      last_q <= 4'(NCH-1);
      cur_q <= '0;
      cur_vld_q <= 1'b0;
      cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      last_q <= last_d;
      cur_q <= cur_d;
      cur_vld_q <= cur_vld_d;
      cnt_q <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
    end
  end
  assign bus.S_READY = s_ready;
  assign bus.M_VALID = m_valid_q;
  assign bus.M_DATA = m_data_q;
  assign o_chan = cur_vld_q ? cur_q : 4'hF;
  assign o_busy = state_q != IDLE;
endmodule

// File: tb/tb_smi_chanmux.sv
// tb_smi_chanmux: randomized and directed scoreboard bench decoding the smi stream like host software
module tb_smi_chanmux;
  localparam int NCH = 4;
  localparam int QD = 1024;
  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic [3:0] o_chan;
  logic o_busy;
  smi_chanmux_if #(.NCH(NCH)) bus();
  smi_chanmux #(.NCH(NCH), .MAX_BURST(4), .LGBURST(2)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .bus(bus.master),
    .o_chan(o_chan),
    .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] drv_mem [NCH][QD];
  logic [7:0] exp_mem [NCH][QD];
  int drv_wr [NCH];
  int drv_rd [NCH];
  int exp_wr [NCH];
  int exp_rd [NCH];
  int rdy_cnt [NCH];
  logic [7:0] exp_s [$];
  bit strict = 0;
  bit chk_en = 1;
  int rdy_mode = 0;
  int cyc = 0;
  int dec_ch = -1;
  bit esc = 0;
  bit pend_v = 0;
  logic [7:0] pend_d;
  logic [NCH-1:0] acc;
  bit rst_seen;
  task automatic chk(string name, int act, int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask
  task automatic enq(int k, logic [7:0] b);
    drv_mem[k][drv_wr[k] % QD] = b;
    drv_wr[k]++;
    exp_mem[k][exp_wr[k] % QD] = b;
    exp_wr[k]++;
  endtask
  task automatic pay(logic [7:0] b);
    if (dec_ch < 0) chk("payload_before_header", int'(b), 256);
    else if (exp_rd[dec_ch] == exp_wr[dec_ch]) chk($sformatf("payload_extra_ch%0d", dec_ch), int'(b), 256);
    else begin
      chk($sformatf("payload_ch%0d", dec_ch), int'(b), int'(exp_mem[dec_ch][exp_rd[dec_ch] % QD]));
      exp_rd[dec_ch]++;
    end
  endtask
  task automatic take(logic [7:0] b);
    if (strict) begin
      if (exp_s.size() == 0) chk("stream_extra_byte", int'(b), 256);
      else chk("stream_byte", int'(b), int'(exp_s.pop_front()));
    end
    if (esc) begin
      esc = 0;
      if (b == 8'h1B) pay(b);
      else if (b[7:4] == 4'h8 && int'(b[3:0]) < NCH) begin
        chk("redundant_header", int'(int'(b[3:0]) == dec_ch), 0);
        dec_ch = int'(b[3:0]);
      end else chk("bad_escape", int'(b), 8'h80);
    end else if (b == 8'h1B) esc = 1;
    else pay(b);
  endtask
  function automatic bit quiet();
    bit q = !bus.M_VALID && !o_busy && exp_s.size() == 0;
    for (int k = 0; k < NCH; k++) q = q && drv_rd[k] == drv_wr[k] && exp_rd[k] == exp_wr[k];
    return q;
  endfunction
  task automatic wait_idle(string name);
    int t = 0;
    bit done = 0;
    while (!done && t < 400) begin
      @(negedge i_clk);
      #1;
      t++;
      done = quiet();
    end
    chk({name, "_drain"}, int'(done), 1);
  endtask
  task automatic do_reset();
    i_reset = 1'b1;
    strict = 0;
    exp_s.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    for (int k = 0; k < NCH; k++) rdy_cnt[k] = 0;
  endtask
  initial begin
    bus.S_VALID = '0;
    bus.S_DATA = '0;
    bus.M_READY = 1'b0;
    forever begin
      @(negedge i_clk);
      acc = bus.S_VALID & bus.S_READY;
      rst_seen = i_reset;
      @(posedge i_clk);
      #2;
      cyc++;
      for (int k = 0; k < NCH; k++) begin
        if (acc[k] && !rst_seen) drv_rd[k]++;
        bus.S_VALID[k] = drv_rd[k] != drv_wr[k];
        bus.S_DATA[8*k +: 8] = drv_mem[k][drv_rd[k] % QD];
      end
      bus.M_READY = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? cyc % 3 == 0 : $urandom_range(3) != 0;
    end
  end
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        dec_ch = -1;
        esc = 0;
        pend_v = 0;
      end else begin
        chk("s_ready_onehot", int'($countones(bus.S_READY) <= 1), 1);
        if (pend_v) begin
          chk("m_hold_valid", int'(bus.M_VALID), 1);
          chk("m_hold_data", int'(bus.M_DATA), int'(pend_d));
        end
        pend_v = bus.M_VALID && !bus.M_READY;
        pend_d = bus.M_DATA;
        for (int k = 0; k < NCH; k++) if (bus.S_READY[k]) rdy_cnt[k]++;
        if (chk_en && bus.M_VALID && bus.M_READY) take(bus.M_DATA);
      end
    end
  end
  initial begin
    bit found;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_m_valid", int'(bus.M_VALID), 0);
    chk("rst_m_data", int'(bus.M_DATA), 0);
    chk("rst_s_ready", int'(bus.S_READY), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_chan", int'(o_chan), 15);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    strict = 1;
    exp_s = {8'h1B, 8'h80, 8'h41, 8'h42};
    enq(0, 8'h41);
    enq(0, 8'h42);
    wait_idle("t1");
    chk("t1_ready_cycles", rdy_cnt[0], 2);
    chk("t1_chan", int'(o_chan), 0);
    do_reset();
    strict = 1;
    exp_s = {8'h1B, 8'h81, 8'h1B, 8'h1B, 8'h55};
    enq(1, 8'h1B);
    enq(1, 8'h55);
    wait_idle("t2");
    chk("t2_ready_cycles", rdy_cnt[1], 2);
    chk("t2_chan", int'(o_chan), 1);
    do_reset();
    strict = 1;
    for (int j = 0; j < 8; j++) begin
      enq(0, 8'hC0 + 8'(j));
      enq(2, 8'hD0 + 8'(j));
    end
    for (int r = 0; r < 4; r++) begin
      exp_s.push_back(8'h1B);
      exp_s.push_back(r % 2 ? 8'h82 : 8'h80);
      for (int j = 0; j < 4; j++) exp_s.push_back((r % 2 ? 8'hD0 : 8'hC0) + 8'(4 * (r / 2) + j));
    end
    wait_idle("t3");
    chk("t3_ready_ch0", rdy_cnt[0], 8);
    chk("t3_ready_ch1", rdy_cnt[1], 0);
    chk("t3_ready_ch3", rdy_cnt[3], 0);
    do_reset();
    strict = 1;
    exp_s = {8'h1B, 8'h83, 8'h31, 8'h32, 8'h33};
    for (int j = 1; j <= 3; j++) enq(3, 8'h30 + 8'(j));
    wait_idle("t4a");
    repeat (5) @(posedge i_clk);
    #1;
    exp_s = {8'h34, 8'h35};
    enq(3, 8'h34);
    enq(3, 8'h35);
    wait_idle("t4b");
    chk("t4_chan", int'(o_chan), 3);
    do_reset();
    strict = 1;
    rdy_mode = 1;
    exp_s = {8'h1B, 8'h80};
    for (int j = 0; j < 8; j++) begin
      exp_s.push_back(8'hA0 + 8'(j));
      enq(0, 8'hA0 + 8'(j));
    end
    wait_idle("t5");
    rdy_mode = 0;
    do_reset();
    chk_en = 0;
    enq(1, 8'h1B);
    enq(1, 8'h77);
    found = 0;
    for (int t = 0; t < 50 && !found; t++) begin
      @(negedge i_clk);
      found = bus.S_VALID[1] && bus.S_READY[1] && bus.S_DATA[15:8] == 8'h1B;
    end
    chk("t6_escape_accepted", int'(found), 1);
    @(posedge i_clk);
    #1;
    chk("t6_busy_in_escape", int'(o_busy), 1);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("t6_m_valid_after_reset", int'(bus.M_VALID), 0);
    chk("t6_chan_after_reset", int'(o_chan), 15);
    exp_rd[1] = exp_wr[1] - 1;
    exp_s = {8'h1B, 8'h81, 8'h77};
    strict = 1;
    chk_en = 1;
    wait_idle("t6");
    do_reset();
    rdy_mode = 2;
    repeat (1500) begin
      @(posedge i_clk);
      #1;
      for (int k = 0; k < NCH; k++)
        if (drv_wr[k] - drv_rd[k] < 6 && $urandom_range(3) == 0)
          enq(k, $urandom_range(7) == 0 ? 8'h1B : 8'($urandom));
    end
    wait_idle("random");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
